// File: rtl/render_pkg.sv
// Shared definitions for the renderer and its frame store: counter widths,
// default render region and write shift, and the double-buffer state type.
// Holds no logic; no latency and no backpressure apply.
package render_pkg;

   localparam int HCOUNT_W = 11;
   localparam int VCOUNT_W = 10;

   // Default render region, shared with renderer_sig_gen.
   localparam int RGN_START_X      = 390;
   localparam int RGN_START_Y      = 390;
   localparam int RGN_END_X        = 634;
   localparam int RGN_END_Y        = 765;
   localparam int RGN_SHIFT_DIVIDE = 530;
   localparam int RGN_SHIFT        = 2;

   // Width of the address arithmetic, so that subtractions that go negative
   // wrap far above any legal column or row.
   localparam int CALC_W = 18;

   typedef enum logic {
      READY   = 1'b0,
      PENDING = 1'b1
   } buf_state_t;

endpackage

// File: rtl/axi_pipe.sv
// Fixed-latency delay line for a bundle of sideband bits.
// Latency: LATENCY cycles; all stages clear on reset.
// Backpressure: none, it advances every cycle.
// Ports: clk_in / rst_in (async, active high), data_in, data_out.
module axi_pipe #(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 2
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] stage [LATENCY];

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= data_in;
         for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
   end

   assign data_out = stage[LATENCY-1];

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Dual-port block RAM, port A writes and port B reads, each on its own clock.
// Latency: port B read is 1 cycle (LOW_LATENCY) or 2 cycles (HIGH_PERFORMANCE).
// Backpressure: none. Contents are never cleared.
// Ports: clka/addra/dina/wea/ena (write), clkb/addrb/enb/rstb/regceb/doutb (read).
module xilinx_true_dual_port_read_first_2_clock_ram #(
   parameter int    RAM_WIDTH       = 12,
   parameter int    RAM_DEPTH       = 1024,
   parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
   localparam int   ADDR_W          = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
   input  logic                 clka,
   input  logic [ADDR_W-1:0]    addra,
   input  logic [RAM_WIDTH-1:0] dina,
   input  logic                 wea,
   input  logic                 ena,
   input  logic                 clkb,
   input  logic [ADDR_W-1:0]    addrb,
   input  logic                 enb,
   input  logic                 rstb,
   input  logic                 regceb,
   output logic [RAM_WIDTH-1:0] doutb
);

   logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] ram_data_b;

   always_ff @(posedge clka) begin
      if (ena && wea) ram[addra] <= dina;
   end

   always_ff @(posedge clkb) begin
      if (enb) ram_data_b <= ram[addrb];
   end

   generate
      if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
         assign doutb = ram_data_b;
      end else begin : g_out_reg
         logic [RAM_WIDTH-1:0] doutb_reg;
         always_ff @(posedge clkb) begin
            if (rstb)        doutb_reg <= '0;
            else if (regceb) doutb_reg <= ram_data_b;
         end
         assign doutb = doutb_reg;
      end
   endgenerate

endmodule

// File: rtl/render_frame_buffer.sv
// Frame store between the renderer pixel stream and VGA scan-out, with an
// optional front/back buffer pair that swaps only on a display new-frame.
// Latency: write lands in RAM 2 cycles after acceptance; scan-out pixel and
// syncs appear 2 cycles after hcount/vcount/ad/hs/vs.
// Backpressure: with two buffers wr_ready_out drops after the frame's last
// pixel and returns on the cycle after the swap; one buffer never stalls.
// Ports: clk_in, rst_in; write side wr_valid_in/wr_ready_out, wr_hcount_in,
// wr_vcount_in, wr_pixel_in, wr_last_in; VGA side hcount_in, vcount_in, ad_in,
// hs_in, vs_in, nf_in; outputs pixel_out, hs_out, vs_out, front_out, swap_out.
import render_pkg::*;

module render_frame_buffer #(
   parameter int START_X      = RGN_START_X,
   parameter int START_Y      = RGN_START_Y,
   parameter int END_X        = RGN_END_X,
   parameter int END_Y        = RGN_END_Y,
   parameter int PIX_BITS     = 12,
   parameter int NUM_BUFS     = 2,
   parameter int SHIFT_DIVIDE = RGN_SHIFT_DIVIDE,
   parameter int SHIFT        = RGN_SHIFT,
   parameter logic [PIX_BITS-1:0] BG = '0
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                wr_valid_in,
   output logic                wr_ready_out,
   input  logic [HCOUNT_W-1:0] wr_hcount_in,
   input  logic [VCOUNT_W-1:0] wr_vcount_in,
   input  logic [PIX_BITS-1:0] wr_pixel_in,
   input  logic                wr_last_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  logic                ad_in,
   input  logic                hs_in,
   input  logic                vs_in,
   input  logic                nf_in,
   output logic [PIX_BITS-1:0] pixel_out,
   output logic                hs_out,
   output logic                vs_out,
   output logic                front_out,
   output logic                swap_out
);

   localparam int W     = END_X - START_X;
   localparam int H     = END_Y - START_Y;
   localparam int DEPTH = W * H;
   localparam int WORDS = NUM_BUFS * DEPTH;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   buf_state_t state;
   logic       front_q;
   logic       swap_q;
   logic       ready_q;
   logic       back;
   logic       wr_accept;

   assign wr_accept    = wr_valid_in && ready_q;
   assign back         = (NUM_BUFS == 2) ? ~front_q : 1'b0;
   assign wr_ready_out = ready_q;
   assign front_out    = front_q;
   assign swap_out     = swap_q;

   // ---------------- write address ----------------
   logic              wr_shifted;
   logic [CALC_W-1:0] wr_col;
   logic [CALC_W-1:0] wr_row;
   logic              wr_in_range;
   logic [AW-1:0]     back_base;
   logic [AW-1:0]     wr_addr_calc;

   assign wr_shifted = CALC_W'(wr_vcount_in) < CALC_W'(SHIFT_DIVIDE);
   assign wr_col     = CALC_W'(wr_hcount_in) - CALC_W'(START_X)
                       - (wr_shifted ? CALC_W'(SHIFT) : CALC_W'(0));
   assign wr_row     = CALC_W'(wr_vcount_in) - CALC_W'(START_Y);
   // Unsigned compare also rejects columns/rows that went below zero.
   assign wr_in_range = (wr_col < CALC_W'(W)) && (wr_row < CALC_W'(H));
   assign back_base   = back ? AW'(DEPTH) : AW'(0);
   // Once in range, col and row both fit in AW bits, so the sum can be
   // formed at address width.
   assign wr_addr_calc = wr_col[AW-1:0] + wr_row[AW-1:0] * AW'(W) + back_base;

   logic                wr_en_q;
   logic [AW-1:0]       wr_addr_q;
   logic [PIX_BITS-1:0] wr_pix_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_pix_q  <= '0;
      end else begin
         // Clipped pixels are still accepted, they just never reach the RAM.
         wr_en_q <= wr_accept && wr_in_range;
         if (wr_accept) begin
            wr_addr_q <= wr_addr_calc;
            wr_pix_q  <= wr_pixel_in;
         end
      end
   end

   // ---------------- read address ----------------
   logic [CALC_W-1:0] rd_col;
   logic [CALC_W-1:0] rd_row;
   logic              in_region;
   logic [AW-1:0]     front_base;
   logic [AW-1:0]     rd_addr_calc;
   logic [AW-1:0]     rd_addr_hold;
   logic [AW-1:0]     rd_addr;

   assign rd_col       = CALC_W'(hcount_in) - CALC_W'(START_X);
   assign rd_row       = CALC_W'(vcount_in) - CALC_W'(START_Y);
   assign in_region    = (rd_col < CALC_W'(W)) && (rd_row < CALC_W'(H));
   assign front_base   = front_q ? AW'(DEPTH) : AW'(0);
   assign rd_addr_calc = rd_col[AW-1:0] + rd_row[AW-1:0] * AW'(W) + front_base;
   // Outside the region the RAM keeps reading the last in-region word;
   // the output mux substitutes BG for it.
   assign rd_addr      = in_region ? rd_addr_calc : rd_addr_hold;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)         rd_addr_hold <= '0;
      else if (in_region) rd_addr_hold <= rd_addr_calc;
   end

   // ---------------- storage and output ----------------
   logic [PIX_BITS-1:0] ram_dout;

   xilinx_true_dual_port_read_first_2_clock_ram #(
      .RAM_WIDTH      (PIX_BITS),
      .RAM_DEPTH      (WORDS),
      .RAM_PERFORMANCE("HIGH_PERFORMANCE")
   ) u_ram (
      .clka  (clk_in),
      .addra (wr_addr_q),
      .dina  (wr_pix_q),
      .wea   (wr_en_q),
      .ena   (1'b1),
      .clkb  (clk_in),
      .addrb (rd_addr),
      .enb   (1'b1),
      .rstb  (rst_in),
      .regceb(1'b1),
      .doutb (ram_dout)
   );

   logic show_d;

   axi_pipe #(
      .WIDTH  (3),
      .LATENCY(2)
   ) u_sync_pipe (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .data_in ({in_region && ad_in, hs_in, vs_in}),
      .data_out({show_d, hs_out, vs_out})
   );

   assign pixel_out = show_d ? ram_dout : BG;

   // ---------------- buffer swap control ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state   <= READY;
         front_q <= 1'b0;
         swap_q  <= 1'b0;
         ready_q <= 1'b1;
      end else if (NUM_BUFS == 2) begin
         swap_q <= 1'b0;
         case (state)
            READY: begin
               if (wr_accept && wr_last_in) begin
                  if (nf_in) begin
                     // Frame finished right on the display boundary: swap now.
                     front_q <= ~front_q;
                     swap_q  <= 1'b1;
                  end else begin
                     state   <= PENDING;
                     ready_q <= 1'b0;
                  end
               end
            end
            PENDING: begin
               if (nf_in) begin
                  state   <= READY;
                  ready_q <= 1'b1;
                  front_q <= ~front_q;
                  swap_q  <= 1'b1;
               end
            end
            default: begin
               state   <= READY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_render_frame_buffer.sv
module tb_render_frame_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] wr_hcount, hcount;
   logic [9:0]  wr_vcount, vcount;
   logic [11:0] wr_pixel;
   logic        wr_last, ad, hs, vs, nf;
   logic        wr_valid1, wr_valid2, wr_valid3;
   logic        rdy1, rdy2, rdy3;
   logic [11:0] pix1, pix2, pix3;
   logic        hs1, hs2, hs3, vs1, vs2, vs3;
   logic        front1, front2, front3, swap1, swap2, swap3;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   render_frame_buffer #(.START_X(0), .START_Y(0), .END_X(4), .END_Y(3), .PIX_BITS(12),
      .NUM_BUFS(1), .SHIFT_DIVIDE(0), .SHIFT(2), .BG(12'hABC)) u1 (
      .clk_in(clk), .rst_in(rst), .wr_valid_in(wr_valid1), .wr_ready_out(rdy1),
      .wr_hcount_in(wr_hcount), .wr_vcount_in(wr_vcount), .wr_pixel_in(wr_pixel),
      .wr_last_in(wr_last), .hcount_in(hcount), .vcount_in(vcount), .ad_in(ad),
      .hs_in(hs), .vs_in(vs), .nf_in(nf), .pixel_out(pix1), .hs_out(hs1), .vs_out(vs1),
      .front_out(front1), .swap_out(swap1));

   render_frame_buffer #(.START_X(0), .START_Y(0), .END_X(4), .END_Y(3), .PIX_BITS(12),
      .NUM_BUFS(2), .SHIFT_DIVIDE(0), .SHIFT(2), .BG(12'hABC)) u2 (
      .clk_in(clk), .rst_in(rst), .wr_valid_in(wr_valid2), .wr_ready_out(rdy2),
      .wr_hcount_in(wr_hcount), .wr_vcount_in(wr_vcount), .wr_pixel_in(wr_pixel),
      .wr_last_in(wr_last), .hcount_in(hcount), .vcount_in(vcount), .ad_in(ad),
      .hs_in(hs), .vs_in(vs), .nf_in(nf), .pixel_out(pix2), .hs_out(hs2), .vs_out(vs2),
      .front_out(front2), .swap_out(swap2));

   render_frame_buffer #(.START_X(0), .START_Y(0), .END_X(4), .END_Y(3), .PIX_BITS(12),
      .NUM_BUFS(1), .SHIFT_DIVIDE(2), .SHIFT(2), .BG(12'hABC)) u3 (
      .clk_in(clk), .rst_in(rst), .wr_valid_in(wr_valid3), .wr_ready_out(rdy3),
      .wr_hcount_in(wr_hcount), .wr_vcount_in(wr_vcount), .wr_pixel_in(wr_pixel),
      .wr_last_in(wr_last), .hcount_in(hcount), .vcount_in(vcount), .ad_in(ad),
      .hs_in(hs), .vs_in(vs), .nf_in(nf), .pixel_out(pix3), .hs_out(hs3), .vs_out(vs3),
      .front_out(front3), .swap_out(swap3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_px(input int inst, input logic [10:0] h, input logic [9:0] v,
                           input logic [11:0] p, input logic last);
      wr_hcount = h; wr_vcount = v; wr_pixel = p; wr_last = last;
      wr_valid1 = (inst == 1); wr_valid2 = (inst == 2); wr_valid3 = (inst == 3);
      tick;
      wr_valid1 = 1'b0; wr_valid2 = 1'b0; wr_valid3 = 1'b0; wr_last = 1'b0;
   endtask

   // Presents one position for a single cycle, then moves off-region, so the
   // value sampled on return is the one launched exactly two edges earlier.
   task automatic read_px(input logic [10:0] h, input logic [9:0] v, input logic a);
      hcount = h; vcount = v; ad = a;
      tick;
      hcount = 11'd7; vcount = 10'd7; ad = 1'b0;
      tick;
   endtask

   task automatic nf_pulse;
      nf = 1'b1;
      tick;
      nf = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      total++; if (rdy2 !== 1'b1) $display("FAIL reset_rdy2: got %b want 1", rdy2); else passed++;
      total++; if (rdy1 !== 1'b1 || rdy3 !== 1'b1) $display("FAIL reset_rdy13: got %b%b want 11", rdy1, rdy3); else passed++;
      total++; if (front2 !== 1'b0 || swap2 !== 1'b0) $display("FAIL reset_front_swap: got %b%b want 00", front2, swap2); else passed++;
      total++; if (pix2 !== 12'hABC) $display("FAIL reset_pixel: got %h want abc", pix2); else passed++;
      total++; if (hs2 !== 1'b0 || vs2 !== 1'b0) $display("FAIL reset_syncs: got %b%b want 00", hs2, vs2); else passed++;
      total++; if ({front3, swap3, hs3, vs3} !== 4'b0) $display("FAIL reset_u3: got %b want 0000", {front3, swap3, hs3, vs3}); else passed++;
      rst = 1'b0;
      tick;
      total++; if (rdy2 !== 1'b1 || pix2 !== 12'hABC) $display("FAIL post_reset: got %b %h want 1 abc", rdy2, pix2); else passed++;
   endtask

   task automatic test_single_buffer;
      for (int v = 0; v < 3; v++)
         for (int h = 0; h < 4; h++)
            write_px(1, 11'(h), 10'(v), 12'(h + 16 * v), 1'b0);
      tick; tick;
      for (int v = 0; v < 3; v++)
         for (int h = 0; h < 4; h++) begin
            read_px(11'(h), 10'(v), 1'b1);
            total++;
            if (pix1 !== 12'(h + 16 * v))
               $display("FAIL single_read(%0d,%0d): got %h want %h", h, v, pix1, 12'(h + 16 * v));
            else passed++;
         end
      read_px(11'd4, 10'd0, 1'b1);
      total++; if (pix1 !== 12'hABC) $display("FAIL oob_h4: got %h want abc", pix1); else passed++;
      read_px(11'd0, 10'd3, 1'b1);
      total++; if (pix1 !== 12'hABC) $display("FAIL oob_v3: got %h want abc", pix1); else passed++;
      read_px(11'd1, 10'd1, 1'b0);
      total++; if (pix1 !== 12'hABC) $display("FAIL ad_low: got %h want abc", pix1); else passed++;
   endtask

   task automatic test_latency;
      logic [10:0] lh [8];
      logic [9:0]  lv [8];
      logic        la [8];
      logic        lhs [8];
      logic        lvs [8];
      logic [11:0] ep [8];
      lh  = '{11'd0, 11'd1, 11'd5, 11'd2, 11'd3, 11'd3, 11'd0, 11'd1};
      lv  = '{10'd0, 10'd0, 10'd0, 10'd1, 10'd2, 10'd2, 10'd2, 10'd1};
      la  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      lhs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      lvs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      ep  = '{12'h000, 12'h001, 12'hABC, 12'h012, 12'hABC, 12'h023, 12'h020, 12'h011};
      for (int j = 0; j <= 8; j++) begin
         if (j < 8) begin
            hcount = lh[j]; vcount = lv[j]; ad = la[j]; hs = lhs[j]; vs = lvs[j];
         end else begin
            ad = 1'b0; hs = 1'b0; vs = 1'b0;
         end
         tick;
         if (j >= 1) begin
            total++;
            if (pix1 !== ep[j-1] || hs1 !== lhs[j-1] || vs1 !== lvs[j-1])
               $display("FAIL stream[%0d]: got %h %b%b want %h %b%b", j - 1, pix1, hs1, vs1,
                        ep[j-1], lhs[j-1], lvs[j-1]);
            else passed++;
         end
      end
   endtask

   task automatic test_double_buffer;
      for (int v = 0; v < 3; v++)
         for (int h = 0; h < 4; h++)
            write_px(2, 11'(h), 10'(v), 12'(12'h100 + h + 16 * v), (v == 2 && h == 3));
      total++; if (rdy2 !== 1'b0) $display("FAIL pending_rdy: got %b want 0", rdy2); else passed++;
      tick; tick;
      nf_pulse;
      total++; if (swap2 !== 1'b1 || front2 !== 1'b1) $display("FAIL swap_a: got %b%b want 11", swap2, front2); else passed++;
      total++; if (swap1 !== 1'b0 || front1 !== 1'b0) $display("FAIL single_ignores_nf: got %b%b want 00", swap1, front1); else passed++;
      tick;
      total++; if (swap2 !== 1'b0) $display("FAIL swap_pulse_width: got %b want 0", swap2); else passed++;
      for (int v = 0; v < 3; v++)
         for (int h = 0; h < 4; h++) begin
            read_px(11'(h), 10'(v), 1'b1);
            total++;
            if (pix2 !== 12'(12'h100 + h + 16 * v))
               $display("FAIL scan_a(%0d,%0d): got %h want %h", h, v, pix2, 12'(12'h100 + h + 16 * v));
            else passed++;
         end
      // Frame B without wr_last: nf_in must not swap.
      for (int v = 0; v < 3; v++)
         for (int h = 0; h < 4; h++)
            write_px(2, 11'(h), 10'(v), 12'(12'h200 + h + 16 * v), 1'b0);
      tick;
      nf_pulse;
      total++; if (swap2 !== 1'b0 || front2 !== 1'b1) $display("FAIL no_swap_b: got %b%b want 01", swap2, front2); else passed++;
      for (int v = 0; v < 3; v++)
         for (int h = 0; h < 4; h++) begin
            read_px(11'(h), 10'(v), 1'b1);
            total++;
            if (pix2 !== 12'(12'h100 + h + 16 * v))
               $display("FAIL scan_still_a(%0d,%0d): got %h want %h", h, v, pix2, 12'(12'h100 + h + 16 * v));
            else passed++;
         end
   endtask

   task automatic test_backpressure;
      write_px(2, 11'd0, 10'd0, 12'h3C0, 1'b1);
      total++; if (rdy2 !== 1'b0) $display("FAIL bp_rdy_drop: got %b want 0", rdy2); else passed++;
      wr_hcount = 11'd1; wr_vcount = 10'd0; wr_pixel = 12'h777; wr_valid2 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         total++; if (rdy2 !== 1'b0) $display("FAIL bp_hold[%0d]: got %b want 0", i, rdy2); else passed++;
      end
      wr_valid2 = 1'b0;
      nf_pulse;
      total++; if (rdy2 !== 1'b1 || swap2 !== 1'b1 || front2 !== 1'b0)
         $display("FAIL bp_release: got %b%b%b want 110", rdy2, swap2, front2); else passed++;
      read_px(11'd1, 10'd0, 1'b1);
      total++; if (pix2 !== 12'h201) $display("FAIL bp_untouched: got %h want 201", pix2); else passed++;
      read_px(11'd0, 10'd0, 1'b1);
      total++; if (pix2 !== 12'h3C0) $display("FAIL bp_last_px: got %h want 3c0", pix2); else passed++;
      read_px(11'd2, 10'd1, 1'b1);
      total++; if (pix2 !== 12'h212) $display("FAIL bp_frame_b: got %h want 212", pix2); else passed++;
   endtask

   task automatic test_simultaneous;
      wr_hcount = 11'd3; wr_vcount = 10'd2; wr_pixel = 12'h4AA; wr_last = 1'b1;
      wr_valid2 = 1'b1; nf = 1'b1;
      tick;
      wr_valid2 = 1'b0; wr_last = 1'b0; nf = 1'b0;
      total++; if (swap2 !== 1'b1 || front2 !== 1'b1 || rdy2 !== 1'b1)
         $display("FAIL simul_swap: got %b%b%b want 111", swap2, front2, rdy2); else passed++;
      tick;
      total++; if (swap2 !== 1'b0 || front2 !== 1'b1) $display("FAIL simul_once: got %b%b want 01", swap2, front2); else passed++;
      nf_pulse;
      total++; if (swap2 !== 1'b0 || front2 !== 1'b1) $display("FAIL simul_no_pending: got %b%b want 01", swap2, front2); else passed++;
      read_px(11'd3, 10'd2, 1'b1);
      total++; if (pix2 !== 12'h4AA) $display("FAIL simul_pixel: got %h want 4aa", pix2); else passed++;
      read_px(11'd0, 10'd0, 1'b1);
      total++; if (pix2 !== 12'h100) $display("FAIL simul_front_a: got %h want 100", pix2); else passed++;
   endtask

   task automatic test_shift;
      write_px(3, 11'd5, 10'd0, 12'h0D3, 1'b0);  // shifted col 3 -> addr 3
      write_px(3, 11'd2, 10'd1, 12'h0C4, 1'b0);  // shifted col 0, row 1 -> addr 4
      write_px(3, 11'd2, 10'd0, 12'h0A0, 1'b0);  // -> addr 0
      write_px(3, 11'd1, 10'd0, 12'h0FF, 1'b0);  // col -1: dropped
      write_px(3, 11'd6, 10'd0, 12'h0EE, 1'b0);  // col 4: dropped
      write_px(3, 11'd1, 10'd2, 12'h0B9, 1'b0);  // row 2 unshifted -> addr 9
      tick; tick;
      read_px(11'd0, 10'd0, 1'b1);
      total++; if (pix3 !== 12'h0A0) $display("FAIL shift_addr0: got %h want 0a0", pix3); else passed++;
      read_px(11'd3, 10'd0, 1'b1);
      total++; if (pix3 !== 12'h0D3) $display("FAIL shift_clip_low: got %h want 0d3", pix3); else passed++;
      read_px(11'd0, 10'd1, 1'b1);
      total++; if (pix3 !== 12'h0C4) $display("FAIL shift_clip_high: got %h want 0c4", pix3); else passed++;
      read_px(11'd1, 10'd2, 1'b1);
      total++; if (pix3 !== 12'h0B9) $display("FAIL shift_divide: got %h want 0b9", pix3); else passed++;
   endtask

   task automatic test_reset_pending;
      write_px(2, 11'd1, 10'd1, 12'h555, 1'b1);
      total++; if (rdy2 !== 1'b0) $display("FAIL rp_pending: got %b want 0", rdy2); else passed++;
      hcount = 11'd0; vcount = 10'd0; ad = 1'b1; hs = 1'b1; vs = 1'b1;
      tick; tick;
      total++; if (hs2 !== 1'b1 || vs2 !== 1'b1 || pix2 !== 12'h100)
         $display("FAIL rp_before: got %b%b %h want 11 100", hs2, vs2, pix2); else passed++;
      #2;
      rst = 1'b1;
      #1;
      total++; if (rdy2 !== 1'b1 || front2 !== 1'b0 || swap2 !== 1'b0)
         $display("FAIL rp_async_ctrl: got %b%b%b want 100", rdy2, front2, swap2); else passed++;
      total++; if (pix2 !== 12'hABC || hs2 !== 1'b0 || vs2 !== 1'b0)
         $display("FAIL rp_async_out: got %h %b%b want abc 00", pix2, hs2, vs2); else passed++;
      ad = 1'b0; hs = 1'b0; vs = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      nf_pulse;
      total++; if (swap2 !== 1'b0 || front2 !== 1'b0 || rdy2 !== 1'b1)
         $display("FAIL rp_no_swap: got %b%b%b want 001", swap2, front2, rdy2); else passed++;
   endtask

   initial begin
      rst = 1'b1;
      wr_hcount = '0; wr_vcount = '0; wr_pixel = '0; wr_last = 1'b0;
      wr_valid1 = 1'b0; wr_valid2 = 1'b0; wr_valid3 = 1'b0;
      hcount = '0; vcount = '0; ad = 1'b0; hs = 1'b0; vs = 1'b0; nf = 1'b0;
      test_reset;
      test_single_buffer;
      test_latency;
      test_double_buffer;
      test_backpressure;
      test_simultaneous;
      test_shift;
      test_reset_pending;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

endmodule
